// File: rtl/proc_pkg.sv
// Shared processor definitions: writeback select encodings, register constants
// and the MDU tracker state type.
package proc_pkg;

    localparam logic [1:0] LOAD_SEL = 2'd1;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CNT_W    = 4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_tracker.sv
// Countdown tracker for the multi-cycle multiply/divide unit; busy_o is high
// while a result is still pending.
module mdu_tracker #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o
);
    import proc_pkg::*;

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: begin
                if (start_i) begin
                    cnt_d   = CNT_W'(MDU_LAT);
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                // A new MDU op restarts the full latency instead of queuing.
                if (start_i) begin
                    cnt_d = CNT_W'(MDU_LAT);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = MDU_IDLE;
                    end
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == MDU_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch squash, ID jumps and
// MDU result interlock. Optional perf counters are built when HAZ_PERF_EN is defined.
module hazard_ctrl #(
    parameter int         MDU_LAT  = 4,
    parameter logic [1:0] LOAD_SEL = proc_pkg::LOAD_SEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        ID_rd_hilo,
    input  logic        ID_mdu_op,
    input  logic        ID_jump,
    input  logic [4:0]  EXE_wraddr,
    input  logic        EXE_wr_en,
    input  logic [1:0]  EXE_sel_data,
    input  logic        EXE_br_taken,
    input  logic        EXE_mdu_start,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        flush,
`ifdef HAZ_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        mdu_busy
);
    import proc_pkg::REG_ZERO;

    logic load_use;
    logic mdu_hold;
    logic stall_req;

    // The MDU start is never gated: the MDU op is older than any squashed path.
    mdu_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_tracker (
        .clk     (clk),
        .rst     (rst),
        .start_i (EXE_mdu_start),
        .busy_o  (mdu_busy)
    );

    always_comb begin
        load_use = EXE_wr_en && (EXE_sel_data == LOAD_SEL) && (EXE_wraddr != REG_ZERO) &&
                   ((ID_use_rs && (ID_rs == EXE_wraddr)) ||
                    (ID_use_rt && (ID_rt == EXE_wraddr)));
        mdu_hold  = (ID_rd_hilo || ID_mdu_op) && (mdu_busy || EXE_mdu_start);
        stall_req = load_use || mdu_hold;
    end

    // Branch squash outranks stalls; a stalled jump waits for its release cycle.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        flush       = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (EXE_br_taken) begin
            if_id_flush = 1'b1;
            flush       = 1'b1;
        end else if (stall_req) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            flush       = 1'b1;
        end else if (ID_jump) begin
            if_id_flush = 1'b1;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, pc_stall};
        flush_cnt_d = flush_cnt_q + {31'd0, (flush | if_id_flush)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a cycle-indexed reference model. Counter checks need HAZ_PERF_EN.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, EXE_wraddr;
    logic        ID_use_rs, ID_use_rt, ID_rd_hilo, ID_mdu_op, ID_jump;
    logic        EXE_wr_en, EXE_br_taken, EXE_mdu_start;
    logic [1:0]  EXE_sel_data;
    logic        pc_stall, if_id_stall, if_id_flush, flush, mdu_busy;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: absolute cycle index and last cycle MDU is busy.
    int          cycleNo   = 0;
    int          busyUntil = -1;
    longint      modelStalls  = 0;
    longint      modelFlushes = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MDU_LAT  (LAT),
        .LOAD_SEL (2'd1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_use_rs     (ID_use_rs),
        .ID_use_rt     (ID_use_rt),
        .ID_rd_hilo    (ID_rd_hilo),
        .ID_mdu_op     (ID_mdu_op),
        .ID_jump       (ID_jump),
        .EXE_wraddr    (EXE_wraddr),
        .EXE_wr_en     (EXE_wr_en),
        .EXE_sel_data  (EXE_sel_data),
        .EXE_br_taken  (EXE_br_taken),
        .EXE_mdu_start (EXE_mdu_start),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .flush         (flush),
`ifdef HAZ_PERF_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .mdu_busy      (mdu_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycleNo, observed, expected);
        end
    endtask

    task automatic clearInputs();
        rst = 1'b0;
        ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
        ID_rd_hilo = 1'b0; ID_mdu_op = 1'b0; ID_jump = 1'b0;
        EXE_wraddr = 5'd0; EXE_wr_en = 1'b0; EXE_sel_data = 2'd0;
        EXE_br_taken = 1'b0; EXE_mdu_start = 1'b0;
    endtask

    task automatic setLoadUse(input logic [4:0] reg_n);
        EXE_wr_en = 1'b1; EXE_sel_data = 2'd1; EXE_wraddr = reg_n;
        ID_use_rs = 1'b1; ID_rs = reg_n;
    endtask

    // Inputs are already driven; check mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input string tag);
        bit busy, hit, luse, hold, stall;
        logic [3:0] exp;
        #3;
        busy  = (cycleNo <= busyUntil);
        hit   = (ID_use_rs && ID_rs == EXE_wraddr) || (ID_use_rt && ID_rt == EXE_wraddr);
        luse  = EXE_wr_en && EXE_sel_data == 2'd1 && EXE_wraddr != 0 && hit;
        hold  = (ID_rd_hilo || ID_mdu_op) && (busy || EXE_mdu_start);
        stall = luse || hold;
        if (rst)               exp = 4'b0000;
        else if (EXE_br_taken) exp = 4'b0011;
        else if (stall)        exp = 4'b1101;
        else if (ID_jump)      exp = 4'b0010;
        else                   exp = 4'b0000;
        // exp = {pc_stall, if_id_stall, if_id_flush, flush}
        checkOutput({tag, ":ctl"}, {28'd0, pc_stall, if_id_stall, if_id_flush, flush}, {28'd0, exp});
        checkOutput({tag, ":busy"}, {31'd0, mdu_busy}, {31'd0, busy});
`ifdef HAZ_PERF_EN
        checkOutput({tag, ":scnt"}, stall_cnt, 32'(modelStalls));
        checkOutput({tag, ":fcnt"}, flush_cnt, 32'(modelFlushes));
`endif
        @(posedge clk);
        if (rst) begin
            busyUntil    = -1;
            modelStalls  = 0;
            modelFlushes = 0;
        end else begin
            if (EXE_mdu_start) busyUntil = cycleNo + LAT;
            modelStalls  += exp[3];
            modelFlushes += (exp[1] | exp[0]);
        end
        cycleNo++;
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("reset");
        clearInputs();
        applyStimulus("idle");

        // Load-use: one stall, then the bubble clears it.
        setLoadUse(5'd5);
        applyStimulus("loaduse");
        EXE_wr_en = 1'b0;
        applyStimulus("loaduse_rel");

        // Load to r0 never interlocks.
        setLoadUse(5'd0);
        applyStimulus("load_r0");
        clearInputs();

        // Taken branch outranks a load-use match.
        setLoadUse(5'd7);
        EXE_br_taken = 1'b1;
        applyStimulus("br_vs_stall");
        clearInputs();

        // HI/LO reader held t..t+LAT, released t+LAT+1.
        ID_rd_hilo = 1'b1;
        EXE_mdu_start = 1'b1;
        applyStimulus("mdu_t0");
        EXE_mdu_start = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) applyStimulus($sformatf("mdu_t%0d", i));
        checkOutput("mdu_released", {31'd0, pc_stall}, 32'd0);
        clearInputs();

        // Jump held by a stall flushes only once released.
        setLoadUse(5'd9);
        ID_jump = 1'b1;
        applyStimulus("jump_stalled");
        EXE_wr_en = 1'b0;
        applyStimulus("jump_released");
        clearInputs();

        // Reset mid-countdown (counter at 2).
        EXE_mdu_start = 1'b1;
        applyStimulus("rstmdu_start");
        EXE_mdu_start = 1'b0;
        applyStimulus("rstmdu_c4");
        applyStimulus("rstmdu_c3");
        rst = 1'b1;
        applyStimulus("rstmdu_rst");
        rst = 1'b0;
        applyStimulus("rstmdu_after");
        checkOutput("rstmdu_busy0", {31'd0, mdu_busy}, 32'd0);

        // Three stall cycles after reset.
        for (int i = 0; i < 3; i++) begin
            setLoadUse(5'd3);
            applyStimulus("perf_stall");
        end
        clearInputs();
        applyStimulus("perf_idle");
`ifdef HAZ_PERF_EN
        checkOutput("perf_stall3", stall_cnt, 32'd3);
`endif

        // Random traffic with narrow register ranges to provoke matches.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            ID_rs         = 5'($urandom_range(0, 3));
            ID_rt         = 5'($urandom_range(0, 3));
            EXE_wraddr    = 5'($urandom_range(0, 3));
            ID_use_rs     = 1'($urandom_range(0, 1));
            ID_use_rt     = 1'($urandom_range(0, 1));
            ID_rd_hilo    = ($urandom_range(0, 3) == 0);
            ID_mdu_op     = ($urandom_range(0, 7) == 0);
            ID_jump       = ($urandom_range(0, 4) == 0);
            EXE_wr_en     = 1'($urandom_range(0, 1));
            EXE_sel_data  = 2'($urandom_range(0, 3));
            EXE_br_taken  = ($urandom_range(0, 5) == 0);
            EXE_mdu_start = ($urandom_range(0, 7) == 0);
            applyStimulus("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage processor; it generates the `flush` consumed by the ID/EXE register and the hold/flush controls for the PC and IF/ID register. It inspects the instruction in ID against the instruction in EXE and handles three cases: load-use interlocks, taken-branch squashes and ID-resolved jumps. It also tracks a multi-cycle multiply/divide unit (MDU) with a countdown so HI/LO readers and back-to-back MDU ops are held until the result is ready.

## Interface
Parameters:
- `MDU_LAT`, 4: MDU result latency in cycles, legal 1..15.
- `LOAD_SEL`, 2'd1: `EXE_sel_data` encoding that marks a load.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset. Reset is synchronous and active-high.
- `ID_rs`, `ID_rt`  in  5 each  source register fields of ID instruction.
- `ID_use_rs`, `ID_use_rt`  in  1 each  ID instruction actually reads rs / rt.
- `ID_rd_hilo`  in  1  ID instruction reads HI/LO (mfhi/mflo).
- `ID_mdu_op`  in  1  ID instruction is mult/div.
- `ID_jump`  in  1  ID instruction is a jump resolved in ID.
- `EXE_wraddr`  in  5  destination of EXE instruction.
- `EXE_wr_en`  in  1  EXE instruction writes the register file.
- `EXE_sel_data`  in  2  EXE writeback source select.
- `EXE_br_taken`  in  1  branch in EXE resolved taken.
- `EXE_mdu_start`  in  1  MDU op in EXE, MDU starts this cycle.
- `pc_stall`  out  1  hold PC.
- `if_id_stall`  out  1  hold IF/ID register.
- `if_id_flush`  out  1  zero IF/ID register.
- `flush`  out  1  bubble ID/EXE control fields.
- `mdu_busy`  out  1  MDU result pending.
- `stall_cnt`, `flush_cnt`  out  32 each  perf counters (only with `HAZ_PERF_EN`).

## Operation
- `load_use` = `EXE_wr_en` & (`EXE_sel_data`==`LOAD_SEL`) & (`EXE_wraddr`!=0) & ((`ID_use_rs` & `ID_rs`==`EXE_wraddr`) | (`ID_use_rt` & `ID_rt`==`EXE_wraddr`)).
- `mdu_hold` = (`ID_rd_hilo` | `ID_mdu_op`) & (`mdu_busy` | `EXE_mdu_start`).
- `stall_req` = `load_use` | `mdu_hold`.
- Priority, highest first:
  1. `rst`: every output is 0.
  2. `EXE_br_taken`: `if_id_flush`=1 and `flush`=1. Stall outputs are 0, because the wrong-path instructions are discarded rather than held.
  3. `stall_req`: `pc_stall`=`if_id_stall`=`flush`=1 and `if_id_flush`=0.
  4. `ID_jump`: `if_id_flush`=1 and all other outputs 0.
  5. Otherwise all outputs are 0.
- A jump that is held by a stall raises no `if_id_flush`. It is re-evaluated on the cycle it is released.
- MDU FSM, with a `CNT_W`=4 counter `mdu_cnt`:
  - IDLE (`mdu_cnt`==0):
    - `EXE_mdu_start` loads `MDU_LAT` and moves to BUSY.
  - BUSY (`mdu_cnt`!=0):
    - Each cycle, decrement.
    - Return to IDLE when the counter reaches 0.
    - `EXE_mdu_start` while BUSY reloads `MDU_LAT` (restart).
  - `mdu_busy` = (`mdu_cnt`!=0), registered.
- `EXE_mdu_start` is honoured even when `EXE_br_taken` is high in the same cycle, since the MDU instruction is older than the squashed ones.

## Timing
- `pc_stall`, `if_id_stall`, `if_id_flush` and `flush` are combinational from the current inputs and `mdu_cnt`, with zero latency. They must be valid before the same rising edge.
- A load-use stall lasts exactly 1 cycle. The bubble inserted into EXE clears the condition on the next cycle.
- With `EXE_mdu_start` at cycle t:
  - `mdu_busy` is 1 for cycles t+1..t+`MDU_LAT`.
  - A HI/LO reader in ID is held from t through t+`MDU_LAT` and released at t+`MDU_LAT`+1.
- Reset mid-countdown: `mdu_cnt` is 0 on the next edge and `mdu_busy` is 0.
- Reset values: all outputs 0, `mdu_cnt`=0, counters 0.

## Configuration
- `HAZ_PERF_EN` defined:
  - `stall_cnt` increments on each cycle with `pc_stall`=1.
  - `flush_cnt` increments on each cycle with `flush`=1 or `if_id_flush`=1.
  - Both are 32-bit, wrap at 2^32, and are cleared by `rst`.
- `HAZ_PERF_EN` undefined: `stall_cnt` and `flush_cnt` ports and logic are absent.

## Structure
- Shared package `proc_pkg` holds:
  - the `LOAD_SEL` encoding;
  - register 0 constant `REG_ZERO`;
  - MDU FSM state enum `{MDU_IDLE, MDU_BUSY}`.
- One natural sub-module: `mdu_tracker`, containing the countdown and `mdu_busy`. The priority logic stays in `hazard_ctrl`.

## Test plan
- Load-use:
  - Stimulus: EXE load to r5 (`EXE_wr_en`=1, `EXE_sel_data`=1, `EXE_wraddr`=5); ID uses rs=5.
  - Response: `pc_stall`=`if_id_stall`=`flush`=1 for one cycle. Next cycle, with `EXE_wr_en`=0, all outputs are 0.
- Load to r0:
  - Stimulus: as above with `EXE_wraddr`=0, `ID_rs`=0.
  - Response: no stall, all outputs 0.
- Branch beats stall:
  - Stimulus: `EXE_br_taken`=1 together with a load-use match.
  - Response: `if_id_flush`=1, `flush`=1, `pc_stall`=0.
- MDU interlock:
  - Stimulus: `MDU_LAT`=4, `EXE_mdu_start` at t, `ID_rd_hilo`=1 from t.
  - Response: stall asserted t..t+4, released t+5. `mdu_busy` is high t+1..t+4.
- Jump under stall:
  - Stimulus: `ID_jump`=1 together with a load-use match.
  - Response: cycle 1 is stall only (`if_id_flush`=0); cycle 2 is `if_id_flush`=1 only.
- Reset and counters:
  - Stimulus: `rst` at mid-countdown (`mdu_cnt`=2).
  - Response: `mdu_busy`=0 next cycle. With `HAZ_PERF_EN`, `stall_cnt` reads 0 after reset and 3 after three stall cycles.
